nn_param_loader: RTL and testbench
==================================

# nn_param_loader

Host-side sequencer that drives the neuron configuration bus (weightValid/biasValid/weightValue/biasValue/config_layer_num/config_neuron_num) of one layer. It accepts a flat stream of 32-bit parameter words over a valid/ready handshake and emits them, one per cycle, as addressed weight and bias writes: neuron 0's weights then its bias, neuron 1's weights then its bias, and so on. It sits between the host DMA/AXI-stream port and the layer's neuron array. It is the writer for the neurons' weight memory and bias register.

## Interface
Parameters:
- dataWidth, 16, neuron data width; only the low dataWidth bits of each word are meaningful to neurons, and the full 32 bits are forwarded.
- maxWeights, 784, largest legal num_weights.
- maxNeurons, 30, largest legal num_neurons.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to program a layer; sampled only in IDLE
- layer_num  in  32  layer to program; latched on accepted start
- num_neurons  in  32  neurons in the layer; latched on accepted start
- num_weights  in  32  weights per neuron; latched on accepted start
- s_data  in  32  parameter word
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts s_data this cycle
- weightValid  out  1  weightValue is a weight for the addressed neuron
- biasValid  out  1  biasValue is the bias for the addressed neuron
- weightValue  out  32  weight word
- biasValue  out  32  bias word
- config_layer_num  out  32  target layer
- config_neuron_num  out  32  target neuron
- busy  out  1  high when not in IDLE
- done  out  1  one-cycle pulse: the layer is fully programmed
- err  out  1  one-cycle pulse: start was rejected

## Operation
- FSM states: IDLE, WEIGHT, BIAS, DONE.
- IDLE + start:
  - If num_neurons==0, num_weights==0, num_weights>maxWeights or num_neurons>maxNeurons: err=1 next cycle and stay in IDLE.
  - Otherwise latch the three inputs, clear neuron_cnt and weight_cnt, and go to WEIGHT.
- s_ready = (state==WEIGHT) | (state==BIAS). A handshake is s_valid & s_ready.
- The loader has no backpressure toward the neurons. The output rate equals the handshake rate.
- WEIGHT, on handshake:
  - Next cycle: weightValid=1, weightValue=s_data, config_neuron_num=neuron_cnt.
  - weight_cnt increments.
  - When weight_cnt==num_weights-1 the state goes to BIAS.
- BIAS, on handshake:
  - Next cycle: biasValid=1, biasValue=s_data, config_neuron_num=neuron_cnt.
  - If neuron_cnt==num_neurons-1, go to DONE. Otherwise neuron_cnt increments, weight_cnt clears, and go to WEIGHT.
- DONE: lasts one cycle and returns to IDLE.
- config_layer_num is the latched layer_num from accepted start until the next accepted start.
- config_neuron_num holds its last value between writes.
- weightValid and biasValid are never both high in the same cycle.
- start outside IDLE is ignored, with no err.
- Counters compare against latched values, so changes on the inputs mid-load have no effect.
- Neuron write addresses only advance on writes, so every neuron must receive exactly num_weights weights. The loader guarantees this by counting.

## Timing
- Reset: state=IDLE and counters=0. Every output (s_ready, weightValid, biasValid, weightValue, biasValue, config_layer_num, config_neuron_num, busy, done, err) is 0.
- All outputs except s_ready are registered. s_ready is decoded from the state register only; it does not depend on s_valid.
- Latency: handshake in cycle t gives weightValid/biasValid in cycle t+1 with matching value and config_neuron_num.
- Accepted start in cycle t: busy=1 and s_ready=1 from t+1.
- Final bias handshake in cycle t:
  - biasValid=1 and done=1 together in t+1 (state DONE, s_ready=0).
  - IDLE and busy=0 in t+2. start may be accepted in t+2.
- Gaps (s_valid=0) insert idle cycles with no write strobes. Counters are unaffected.
- rst mid-load aborts immediately: no further strobes, no done. Neurons partially written must also be reset by the system before reloading.

## Configuration
- LOADER_BIAS_EN defined:
  - The sequence includes one bias word after each neuron's weights, as described above.
- LOADER_BIAS_EN undefined (biases come from pretrained files):
  - The BIAS state is removed. biasValid and biasValue are tied to 0.
  - After weight num_weights-1 of the last neuron, go to DONE. For other neurons, neuron_cnt increments and the state stays in WEIGHT.
  - Stream length is num_neurons*num_weights words.

## Structure
- Shared package nn_loader_pkg holds:
  - the state enum (IDLE, WEIGHT, BIAS, DONE)
  - localparams for counter widths, $clog2(maxWeights) and $clog2(maxNeurons)
  - the 32-bit config word width
- No sub-module. The FSM, two counters and output registers are implemented inline.

## Test plan
- Basic load: layer_num=2, num_neurons=3, num_weights=4, words 1..15 with s_valid continuous.
  - Required: weights 1-4 go to neuron 0 and bias 5; weights 6-9 go to neuron 1 and bias 10; weights 11-14 go to neuron 2 and bias 15.
  - config_layer_num=2 throughout. done coincides with biasValid for word 15.
- Bubbles: same load with s_valid toggling 1,0,1,0.
  - Required: identical strobe/value/neuron sequence, with each strobe one cycle after its handshake and none during gaps.
- Illegal start: num_weights=0, then num_weights=785.
  - Required: err pulse one cycle after each start, s_ready stays 0, busy stays 0.
- Reset mid-load: assert rst after weight 3 of neuron 1.
  - Required: all outputs 0 next cycle. A fresh start then restarts at neuron 0.
- Start while busy: pulse start during WEIGHT.
  - Required: ignored; the sequence and done timing are unchanged.
- LOADER_BIAS_EN undefined, num_neurons=2, num_weights=3, words 1..6.
  - Required: neuron 0 gets 1-3 and neuron 1 gets 4-6. biasValid is never 1. done arrives with the strobe for word 6.

Source files
------------

// File: rtl/nn_loader_pkg.sv
// rtl/nn_loader_pkg.sv - shared state encoding and widths for the layer parameter loader
package nn_loader_pkg;

   localparam int CFG_W       = 32;
   localparam int MAX_WEIGHTS = 784;
   localparam int MAX_NEURONS = 30;
   localparam int WCNT_W      = $clog2(MAX_WEIGHTS);
   localparam int NCNT_W      = $clog2(MAX_NEURONS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WEIGHT = 2'd1,
      BIAS   = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/nn_param_loader.sv
// rtl/nn_param_loader.sv - streams weight/bias words onto one layer's neuron config bus
// Optional feature macro: LOADER_BIAS_EN (one bias word after each neuron's weights).
module nn_param_loader
   import nn_loader_pkg::*;
#(
   parameter int dataWidth  = 16,
   parameter int maxWeights = 784,
   parameter int maxNeurons = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CFG_W-1:0] layer_num,
   input  logic [CFG_W-1:0] num_neurons,
   input  logic [CFG_W-1:0] num_weights,
   input  logic [CFG_W-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             weightValid,
   output logic             biasValid,
   output logic [CFG_W-1:0] weightValue,
   output logic [CFG_W-1:0] biasValue,
   output logic [CFG_W-1:0] config_layer_num,
   output logic [CFG_W-1:0] config_neuron_num,
   output logic             busy,
   output logic             done,
   output logic             err
);

   // Counter widths come from the package; reject builds whose limits would overflow them.
   if (dataWidth < 1 || dataWidth > CFG_W) begin : g_bad_data_width
      $error("nn_param_loader: dataWidth out of range");
   end
   if ($clog2(maxWeights) > WCNT_W || $clog2(maxNeurons) > NCNT_W) begin : g_bad_limits
      $error("nn_param_loader: maxWeights/maxNeurons exceed counter widths");
   end

   state_e              state_q, state_d;
   logic [WCNT_W-1:0]   weight_cnt_q, weight_cnt_d;
   logic [NCNT_W-1:0]   neuron_cnt_q, neuron_cnt_d;
   logic [CFG_W-1:0]    layer_q, layer_d;
   logic [CFG_W-1:0]    nn_q, nn_d;
   logic [CFG_W-1:0]    nw_q, nw_d;
   logic                wvalid_q, wvalid_d;
   logic [CFG_W-1:0]    wvalue_q, wvalue_d;
   logic [CFG_W-1:0]    neuron_num_q, neuron_num_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
`ifdef LOADER_BIAS_EN
   logic                bvalid_q, bvalid_d;
   logic [CFG_W-1:0]    bvalue_q, bvalue_d;
`endif

   logic hs;
   logic illegal;
   logic last_w;
   logic last_n;

   assign s_ready = (state_q == WEIGHT) || (state_q == BIAS);
   assign hs      = s_valid && s_ready;
   assign illegal = (num_neurons == '0) || (num_weights == '0) ||
                    (num_weights > CFG_W'(maxWeights)) || (num_neurons > CFG_W'(maxNeurons));
   assign last_w  = (CFG_W'(weight_cnt_q) == nw_q - CFG_W'(1));
   assign last_n  = (CFG_W'(neuron_cnt_q) == nn_q - CFG_W'(1));

   always_comb begin
      state_d      = state_q;
      weight_cnt_d = weight_cnt_q;
      neuron_cnt_d = neuron_cnt_q;
      layer_d      = layer_q;
      nn_d         = nn_q;
      nw_d         = nw_q;
      wvalid_d     = 1'b0;
      wvalue_d     = wvalue_q;
      neuron_num_d = neuron_num_q;
      err_d        = 1'b0;
`ifdef LOADER_BIAS_EN
      bvalid_d     = 1'b0;
      bvalue_d     = bvalue_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               if (illegal) begin
                  err_d = 1'b1;
               end else begin
                  layer_d      = layer_num;
                  nn_d         = num_neurons;
                  nw_d         = num_weights;
                  weight_cnt_d = '0;
                  neuron_cnt_d = '0;
                  state_d      = WEIGHT;
               end
            end
         end
         WEIGHT: begin
            if (hs) begin
               wvalid_d     = 1'b1;
               wvalue_d     = s_data;
               neuron_num_d = CFG_W'(neuron_cnt_q);
               weight_cnt_d = weight_cnt_q + WCNT_W'(1);
               if (last_w) begin
`ifdef LOADER_BIAS_EN
                  state_d = BIAS;
`else
                  if (last_n) begin
                     state_d = DONE;
                  end else begin
                     neuron_cnt_d = neuron_cnt_q + NCNT_W'(1);
                     weight_cnt_d = '0;
                  end
`endif
               end
            end
         end
`ifdef LOADER_BIAS_EN
         BIAS: begin
            if (hs) begin
               bvalid_d     = 1'b1;
               bvalue_d     = s_data;
               neuron_num_d = CFG_W'(neuron_cnt_q);
               if (last_n) begin
                  state_d = DONE;
               end else begin
                  neuron_cnt_d = neuron_cnt_q + NCNT_W'(1);
                  weight_cnt_d = '0;
                  state_d      = WEIGHT;
               end
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // done and busy are registered copies of where the FSM is heading.
      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         weight_cnt_q <= '0;
         neuron_cnt_q <= '0;
         layer_q      <= '0;
         nn_q         <= '0;
         nw_q         <= '0;
         wvalid_q     <= 1'b0;
         wvalue_q     <= '0;
         neuron_num_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
`ifdef LOADER_BIAS_EN
         bvalid_q     <= 1'b0;
         bvalue_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         weight_cnt_q <= weight_cnt_d;
         neuron_cnt_q <= neuron_cnt_d;
         layer_q      <= layer_d;
         nn_q         <= nn_d;
         nw_q         <= nw_d;
         wvalid_q     <= wvalid_d;
         wvalue_q     <= wvalue_d;
         neuron_num_q <= neuron_num_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
`ifdef LOADER_BIAS_EN
         bvalid_q     <= bvalid_d;
         bvalue_q     <= bvalue_d;
`endif
      end
   end

   assign weightValid       = wvalid_q;
   assign weightValue       = wvalue_q;
   assign config_layer_num  = layer_q;
   assign config_neuron_num = neuron_num_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign err               = err_q;
`ifdef LOADER_BIAS_EN
   assign biasValid         = bvalid_q;
   assign biasValue         = bvalue_q;
`else
   assign biasValid         = 1'b0;
   assign biasValue         = '0;
`endif

endmodule

// File: tb/tb_nn_param_loader.sv
// tb/tb_nn_param_loader.sv - directed self-checking bench for nn_param_loader (both LOADER_BIAS_EN builds)
module tb_nn_param_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] layer_num, num_neurons, num_weights, s_data;
   logic        s_valid;
   logic        s_ready, weightValid, biasValid, busy, done, err;
   logic [31:0] weightValue, biasValue, config_layer_num, config_neuron_num;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef LOADER_BIAS_EN
   localparam bit HAS_BIAS = 1'b1;
`else
   localparam bit HAS_BIAS = 1'b0;
`endif

   always #5 clk = ~clk;

   nn_param_loader dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .layer_num         (layer_num),
      .num_neurons       (num_neurons),
      .num_weights       (num_weights),
      .s_data            (s_data),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .weightValid       (weightValid),
      .biasValid         (biasValid),
      .weightValue       (weightValue),
      .biasValue         (biasValue),
      .config_layer_num  (config_layer_num),
      .config_neuron_num (config_neuron_num),
      .busy              (busy),
      .done              (done),
      .err               (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".s_ready"}, s_ready, 0);
      check({tag, ".weightValid"}, weightValid, 0);
      check({tag, ".biasValid"}, biasValid, 0);
      check({tag, ".weightValue"}, weightValue, 0);
      check({tag, ".biasValue"}, biasValue, 0);
      check({tag, ".layer"}, config_layer_num, 0);
      check({tag, ".neuron"}, config_neuron_num, 0);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".done"}, done, 0);
      check({tag, ".err"}, err, 0);
   endtask

   task automatic do_start(input int l, input int nn, input int nw, input bit legal);
      start       = 1'b1;
      layer_num   = l;
      num_neurons = nn;
      num_weights = nw;
      step();
      start = 1'b0;
      // scramble inputs so only the latched copies can be in use
      layer_num   = 32'hdead;
      num_neurons = 32'd0;
      num_weights = 32'hffff;
      check("start.err", err, !legal);
      check("start.busy", busy, legal);
      check("start.s_ready", s_ready, legal);
      if (!legal) begin
         step();
         check("start.err_pulse", err, 0);
         check("start.busy_idle", busy, 0);
         check("start.s_ready_idle", s_ready, 0);
      end
   endtask

   // Feeds nfeed words (or the whole layer when nfeed<0); start_at pulses a stray start with that word.
   task automatic run_load(input int l, input int nn, input int nw, input int nfeed,
                           input bit bubbles, input int start_at);
      int  per;
      int  total;
      int  cnt;
      bit  is_bias;
      per   = HAS_BIAS ? nw + 1 : nw;
      total = per * nn;
      cnt   = (nfeed < 0) ? total : nfeed;
      for (int k = 0; k < cnt; k++) begin
         s_valid = 1'b1;
         s_data  = k + 1;
         if (k == start_at) begin
            start       = 1'b1;
            layer_num   = 9;
            num_neurons = 1;
            num_weights = 1;
         end
         check("load.s_ready", s_ready, 1);
         step();
         s_valid = 1'b0;
         start   = 1'b0;
         is_bias = HAS_BIAS && ((k % per) == nw);
         check("load.weightValid", weightValid, !is_bias);
         check("load.biasValid", biasValid, is_bias);
         if (is_bias) check("load.biasValue", biasValue, k + 1);
         else         check("load.weightValue", weightValue, k + 1);
         check("load.neuron", config_neuron_num, k / per);
         check("load.layer", config_layer_num, l);
         check("load.done", done, (k == total - 1));
         check("load.err", err, 0);
         if (bubbles && k != cnt - 1) begin
            step();
            check("gap.weightValid", weightValid, 0);
            check("gap.biasValid", biasValid, 0);
            check("gap.done", done, 0);
         end
      end
      if (cnt == total) begin
         check("end.s_ready", s_ready, 0);
         check("end.busy", busy, 1);
         step();
         check("idle.busy", busy, 0);
         check("idle.done", done, 0);
         check("idle.s_ready", s_ready, 0);
         check("idle.strobe", weightValid | biasValid, 0);
      end
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      layer_num   = '0;
      num_neurons = '0;
      num_weights = '0;
      s_data      = '0;
      s_valid     = 1'b0;
      step();
      step();
      check_all_zero("reset");
      rst = 1'b0;
      step();

      // basic continuous load, then an accepted start in the first idle cycle
      do_start(2, 3, 4, 1'b1);
      run_load(2, 3, 4, -1, 1'b0, -1);
      do_start(7, 2, 3, 1'b1);
      run_load(7, 2, 3, -1, 1'b0, -1);

      // bubbles between every word
      do_start(2, 3, 4, 1'b1);
      run_load(2, 3, 4, -1, 1'b1, -1);

      // illegal starts
      do_start(1, 3, 0, 1'b0);
      do_start(1, 3, 785, 1'b0);
      do_start(1, 0, 4, 1'b0);
      do_start(1, 31, 4, 1'b0);
      do_start(3, 30, 784, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;

      // reset mid-load after neuron 1's third weight, then a fresh load from neuron 0
      do_start(5, 3, 4, 1'b1);
      run_load(5, 3, 4, HAS_BIAS ? 8 : 7, 1'b0, -1);
      rst = 1'b1;
      step();
      check_all_zero("midrst");
      rst = 1'b0;
      step();
      check("midrst.busy", busy, 0);
      check("midrst.strobe", weightValid | biasValid, 0);
      do_start(6, 3, 4, 1'b1);
      run_load(6, 3, 4, -1, 1'b0, -1);

      // stray start during WEIGHT is ignored
      do_start(2, 3, 4, 1'b1);
      run_load(2, 3, 4, -1, 1'b0, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got %0d expected %0d", 0, 1);
      $fatal(1);
   end

endmodule
